cc_reporter: RTL

- Reads the processor's cycle counter when the program halts (opcode 0).
- Snapshots the count and sends it as a little-endian byte stream to the UART transmitter over a start/done handshake.
- Sits between the cycle counter / instruction decoder and the debug UART TX.
- Sends exactly one report per program run. Re-arms when a non-zero opcode is seen again.

---
 rtl/cc_reporter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cc_reporter.sv
// -----------------------------------------------------------------------------
// cc_reporter
//
// Purpose:
//   Captures the processor cycle counter when the program halts (opcode 0)
//   and streams the captured value to a byte-wide UART transmitter,
//   least-significant byte first, using a start/done handshake. Exactly one
//   report is produced per program run; the block re-arms once a non-zero
//   opcode appears again after the report has finished.
//
// Ports:
//   i_clock      in   1                system clock, rising edge
//   i_reset      in   1                asynchronous reset, active low
//   i_opcode     in   OPCODE_LENGTH    current decoder opcode, 0 = halt
//   i_cuenta     in   CONTADOR_LENGTH  live cycle count
//   o_tx_data    out  BYTE_LENGTH      byte presented to the UART TX
//   o_tx_start   out  1                one-cycle transmit request
//   i_tx_done    in   1                one-cycle pulse: current byte sent
//   o_reportando out  1                high while a report is in progress
//   o_done       out  1                sticky "report complete" flag
// -----------------------------------------------------------------------------
module cc_reporter #(
    parameter int CONTADOR_LENGTH = 11,
    parameter int OPCODE_LENGTH   = 5,
    parameter int BYTE_LENGTH     = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [OPCODE_LENGTH-1:0]   i_opcode,
    input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
    output logic [BYTE_LENGTH-1:0]     o_tx_data,
    output logic                       o_tx_start,
    input  logic                       i_tx_done,
    output logic                       o_reportando,
    output logic                       o_done
);

    // Number of bytes needed to carry the whole count.
    localparam int N_BYTES = (CONTADOR_LENGTH + BYTE_LENGTH - 1) / BYTE_LENGTH;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int EXT_W   = N_BYTES * BYTE_LENGTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                     state_reg;
    logic [CONTADOR_LENGTH-1:0] snapshot_reg;
    logic [IDX_W-1:0]           index_reg;

    logic                       opcode_halt;
    logic [EXT_W-1:0]           snapshot_ext;
    logic [BYTE_LENGTH-1:0]     byte_lane [N_BYTES];

    assign opcode_halt = (i_opcode == '0);

    // Zero-extend the snapshot to a whole number of bytes so the unused
    // upper bits of the most significant byte are transmitted as zeros.
    assign snapshot_ext = EXT_W'(snapshot_reg);

    // Split the extended snapshot into byte lanes; lane 0 is the LSB.
    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane
            assign byte_lane[gi] = snapshot_ext[gi*BYTE_LENGTH +: BYTE_LENGTH];
        end
    endgenerate

    // Single-process FSM with all outputs registered.
    //   o_tx_start is raised on the LOAD->SEND transition, so it is high for
    //   exactly the SEND cycle and drops automatically on the next edge.
    //   o_reportando is raised on entry to LOAD and dropped on WAIT->DONE,
    //   which covers LOAD, SEND and WAIT (including WAIT->LOAD loops).
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= ST_IDLE;
            snapshot_reg <= '0;
            index_reg    <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_reportando <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // A halt seen before any instruction ran is not reported.
                    if (!opcode_halt) begin
                        state_reg <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    // The counter holds during halt, so sampling on the halt
                    // edge captures every non-halt cycle of the run.
                    if (opcode_halt) begin
                        snapshot_reg <= i_cuenta;
                        index_reg    <= '0;
                        o_reportando <= 1'b1;
                        state_reg    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    o_tx_data  <= byte_lane[index_reg];
                    o_tx_start <= 1'b1;
                    state_reg  <= ST_SEND;
                end

                ST_SEND: begin
                    // i_tx_done is deliberately not looked at here: a done
                    // pulse coincident with the start request is stale.
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    // No timeout: the UART may take arbitrarily long.
                    if (i_tx_done) begin
                        if (index_reg == LAST_IDX) begin
                            o_reportando <= 1'b0;
                            o_done       <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            index_reg <= index_reg + 1'b1;
                            state_reg <= ST_LOAD;
                        end
                    end
                end

                ST_DONE: begin
                    // A new instruction means a new run: re-arm for it.
                    if (!opcode_halt) begin
                        o_done    <= 1'b0;
                        state_reg <= ST_ARMED;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
